// File: rtl/alu_functional_unit_pkg.sv
// Shared types for the integer ALU functional unit.
// Provides the GPR/ROB index widths, the ALU opcode and NZCV flag types, and
// the result payload carried from the compute stage through the result FIFO.
package alu_functional_unit_pkg;

    localparam int unsigned GPR_SIZE     = 64;
    localparam int unsigned ROB_IDX_SIZE = 4;
    localparam int unsigned SHAMT_SIZE   = 6;

    typedef enum logic [3:0] {
        ALU_PLUS  = 4'd0,
        ALU_MINUS = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_EOR   = 4'd4,
        ALU_ORN   = 4'd5,
        ALU_MOV   = 4'd6,
        ALU_LSL   = 4'd7,
        ALU_LSR   = 4'd8,
        ALU_ASR   = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef struct packed {
        logic [GPR_SIZE-1:0]     value;
        logic [ROB_IDX_SIZE-1:0] dst_rob_index;
        logic                    set_nzcv;
        nzcv_t                   nzcv;
    } alu_result_t;

endpackage

// File: rtl/alu_functional_unit_compute.sv
// Combinational 64-bit integer ALU with NZCV flag generation.
// Ports:
//   op, a, b        - operation and operands
//   set_nzcv        - compute fresh flags when 1, otherwise pass nzcv_in through
//   nzcv_in         - incoming flags
//   result_c        - 64-bit result (operand a for an undecoded op)
//   nzcv_out_c      - resulting flags
//   bad_op_c        - op did not decode
module alu_compute
    import alu_functional_unit_pkg::*;
(
    input  alu_op_t             op,
    input  logic [GPR_SIZE-1:0] a,
    input  logic [GPR_SIZE-1:0] b,
    input  logic                set_nzcv,
    input  nzcv_t               nzcv_in,
    output logic [GPR_SIZE-1:0] result_c,
    output nzcv_t               nzcv_out_c,
    output logic                bad_op_c
);

    localparam int unsigned MSB = GPR_SIZE - 1;

    logic [GPR_SIZE:0]   sum_c;
    logic [GPR_SIZE-1:0] diff_c;
    logic [SHAMT_SIZE-1:0] shamt_c;
    logic                carry_c;
    logic                ovf_c;

    // Result, carry and overflow selection, then flag merge
    always_comb begin
        sum_c    = {1'b0, a} + {1'b0, b};
        diff_c   = a - b;
        shamt_c  = b[SHAMT_SIZE-1:0];
        result_c = a;
        carry_c  = 1'b0;
        ovf_c    = 1'b0;
        bad_op_c = 1'b0;

        case (op)
            ALU_PLUS: begin
                result_c = sum_c[GPR_SIZE-1:0];
                carry_c  = sum_c[GPR_SIZE];
                ovf_c    = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);
            end
            ALU_MINUS: begin
                result_c = diff_c;
                // No borrow means a >= b unsigned
                carry_c  = (a >= b);
                ovf_c    = (a[MSB] != b[MSB]) && (diff_c[MSB] != a[MSB]);
            end
            ALU_AND:  result_c = a & b;
            ALU_OR:   result_c = a | b;
            ALU_EOR:  result_c = a ^ b;
            ALU_ORN:  result_c = a | ~b;
            ALU_MOV:  result_c = b;
            ALU_LSL:  result_c = a << shamt_c;
            ALU_LSR:  result_c = a >> shamt_c;
            ALU_ASR:  result_c = $unsigned($signed(a) >>> shamt_c);
            default:  bad_op_c = 1'b1;
        endcase

        nzcv_out_c = nzcv_in;
        if (set_nzcv) begin
            nzcv_out_c = '{n: result_c[MSB], z: (result_c == '0), c: carry_c, v: ovf_c};
        end
    end

endmodule

// File: rtl/alu_functional_unit.sv
// Integer ALU functional unit between the reservation station and the ROB.
// One E1 register stage captures an issued instruction; the combinational
// ALU result is pushed into a small result FIFO whose head is presented to
// the ROB with a done/accept handshake.
// Ports:
//   in_clk, in_rst          - clock, synchronous active-high reset
//   in_rs_*                 - issue port from the reservation station
//   in_rob_accept           - ROB consumes the head result
//   in_rob_is_mispred       - flush all in-flight work
//   out_rs_ready            - registered, conservative issue permission
//   out_rob_*               - FIFO head result towards the ROB
//   out_err_overflow        - sticky: start dropped for lack of space
//   out_err_bad_op          - sticky: undecoded op seen
module alu_functional_unit
    import alu_functional_unit_pkg::*;
#(
    parameter int unsigned RES_DEPTH    = 4,
    parameter int unsigned RES_IDX_SIZE = 2
)(
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_rs_start,
    input  alu_op_t                 in_rs_op,
    input  logic [GPR_SIZE-1:0]     in_rs_val_a,
    input  logic [GPR_SIZE-1:0]     in_rs_val_b,
    input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
    input  logic                    in_rs_set_nzcv,
    input  nzcv_t                   in_rs_nzcv,
    input  logic                    in_rob_accept,
    input  logic                    in_rob_is_mispred,
    output logic                    out_rs_ready,
    output logic                    out_rob_done,
    output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic [GPR_SIZE-1:0]     out_rob_value,
    output logic                    out_rob_set_nzcv,
    output nzcv_t                   out_rob_nzcv,
    output logic                    out_err_overflow,
    output logic                    out_err_bad_op
);

    localparam int unsigned CNT_SIZE = RES_IDX_SIZE + 1;
    localparam int unsigned OCC_SIZE = CNT_SIZE + 1;
    localparam logic [CNT_SIZE-1:0] CNT_FULL      = CNT_SIZE'(RES_DEPTH);
    localparam logic [OCC_SIZE-1:0] OCC_READY_MAX = OCC_SIZE'(RES_DEPTH - 1);

    // E1 stage
    logic                    e1_valid;
    alu_op_t                 e1_op;
    logic [GPR_SIZE-1:0]     e1_a;
    logic [GPR_SIZE-1:0]     e1_b;
    logic [ROB_IDX_SIZE-1:0] e1_dst;
    logic                    e1_set_nzcv;
    nzcv_t                   e1_nzcv;

    // Compute outputs
    logic [GPR_SIZE-1:0]     e1_result_c;
    nzcv_t                   e1_nzcv_out_c;
    logic                    e1_bad_op_c;

    // Result FIFO
    alu_result_t             fifo_mem [RES_DEPTH];
    alu_result_t             head_c;
    logic [RES_IDX_SIZE-1:0] rd_ptr;
    logic [RES_IDX_SIZE-1:0] wr_ptr;
    logic [CNT_SIZE-1:0]     count;

    logic                    rs_ready;
    logic                    err_overflow;
    logic                    err_bad_op;

    // Next-state controls
    logic                    pop_c;
    logic                    push_c;
    logic                    start_take_c;
    logic                    overflow_c;
    logic                    e1_valid_next_c;
    logic [CNT_SIZE-1:0]     count_next_c;
    logic [OCC_SIZE-1:0]     occ_next_c;
    logic                    ready_next_c;

    alu_compute u_compute (
        .op         (e1_op),
        .a          (e1_a),
        .b          (e1_b),
        .set_nzcv   (e1_set_nzcv),
        .nzcv_in    (e1_nzcv),
        .result_c   (e1_result_c),
        .nzcv_out_c (e1_nzcv_out_c),
        .bad_op_c   (e1_bad_op_c)
    );

    // Push/pop/start resolution and the conservative ready for the next cycle
    always_comb begin
        pop_c           = in_rob_accept && (count != '0);
        // A pop in the same cycle frees the slot the E1 result needs
        push_c          = e1_valid && ((count != CNT_FULL) || pop_c);
        // E1 can take a new instruction if it is empty or draining now
        start_take_c    = in_rs_start && (!e1_valid || push_c);
        overflow_c      = in_rs_start && e1_valid && !push_c;
        e1_valid_next_c = start_take_c || (e1_valid && !push_c);
        count_next_c    = count + CNT_SIZE'(push_c) - CNT_SIZE'(pop_c);
        occ_next_c      = OCC_SIZE'(count_next_c) + OCC_SIZE'(e1_valid_next_c);
        // Keep one slot spare for an RS that sees ready a cycle late
        ready_next_c    = (occ_next_c <= OCC_READY_MAX);
    end

    // Control state: E1 valid, FIFO pointers/count, ready and error flags
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            e1_valid     <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            rs_ready     <= 1'b1;
            err_overflow <= 1'b0;
            err_bad_op   <= 1'b0;
            for (int unsigned i = 0; i < RES_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (e1_valid && e1_bad_op_c) begin
                err_bad_op <= 1'b1;
            end
            if (in_rob_is_mispred) begin
                e1_valid <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                rs_ready <= 1'b1;
            end else begin
                if (overflow_c) begin
                    err_overflow <= 1'b1;
                end
                if (push_c) begin
                    fifo_mem[wr_ptr] <= '{value:         e1_result_c,
                                          dst_rob_index: e1_dst,
                                          set_nzcv:      e1_set_nzcv,
                                          nzcv:          e1_nzcv_out_c};
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count    <= count_next_c;
                e1_valid <= e1_valid_next_c;
                rs_ready <= ready_next_c;
            end
        end
    end

    // E1 payload; only meaningful while e1_valid, so no reset needed
    always_ff @(posedge in_clk) begin
        if (!in_rst && !in_rob_is_mispred && start_take_c) begin
            e1_op       <= in_rs_op;
            e1_a        <= in_rs_val_a;
            e1_b        <= in_rs_val_b;
            e1_dst      <= in_rs_dst_rob_index;
            e1_set_nzcv <= in_rs_set_nzcv;
            e1_nzcv     <= in_rs_nzcv;
        end
    end

    assign head_c                = fifo_mem[rd_ptr];
    assign out_rs_ready          = rs_ready;
    assign out_rob_done          = (count != '0);
    assign out_rob_dst_rob_index = head_c.dst_rob_index;
    assign out_rob_value         = head_c.value;
    assign out_rob_set_nzcv      = head_c.set_nzcv;
    assign out_rob_nzcv          = head_c.nzcv;
    assign out_err_overflow      = err_overflow;
    assign out_err_bad_op        = err_bad_op;

endmodule

// File: tb/tb_alu_functional_unit.sv
// Self-checking bench for alu_functional_unit: directed spec vectors,
// skid/overflow, mispredict flush, bad op and randomized traffic against a
// queue-based reference model.
module tb_alu_functional_unit;
    import alu_functional_unit_pkg::*;

    localparam int unsigned RES_DEPTH = 4;

    logic                    in_clk = 1'b0;
    logic                    in_rst;
    logic                    in_rs_start;
    alu_op_t                 in_rs_op;
    logic [GPR_SIZE-1:0]     in_rs_val_a;
    logic [GPR_SIZE-1:0]     in_rs_val_b;
    logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index;
    logic                    in_rs_set_nzcv;
    nzcv_t                   in_rs_nzcv;
    logic                    in_rob_accept;
    logic                    in_rob_is_mispred;
    logic                    out_rs_ready;
    logic                    out_rob_done;
    logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index;
    logic [GPR_SIZE-1:0]     out_rob_value;
    logic                    out_rob_set_nzcv;
    nzcv_t                   out_rob_nzcv;
    logic                    out_err_overflow;
    logic                    out_err_bad_op;

    int total = 0;
    int bad   = 0;

    always #5 in_clk = ~in_clk;

    alu_functional_unit #(.RES_DEPTH(4), .RES_IDX_SIZE(2)) dut (
        .in_clk                (in_clk),
        .in_rst                (in_rst),
        .in_rs_start           (in_rs_start),
        .in_rs_op              (in_rs_op),
        .in_rs_val_a           (in_rs_val_a),
        .in_rs_val_b           (in_rs_val_b),
        .in_rs_dst_rob_index   (in_rs_dst_rob_index),
        .in_rs_set_nzcv        (in_rs_set_nzcv),
        .in_rs_nzcv            (in_rs_nzcv),
        .in_rob_accept         (in_rob_accept),
        .in_rob_is_mispred     (in_rob_is_mispred),
        .out_rs_ready          (out_rs_ready),
        .out_rob_done          (out_rob_done),
        .out_rob_dst_rob_index (out_rob_dst_rob_index),
        .out_rob_value         (out_rob_value),
        .out_rob_set_nzcv      (out_rob_set_nzcv),
        .out_rob_nzcv          (out_rob_nzcv),
        .out_err_overflow      (out_err_overflow),
        .out_err_bad_op        (out_err_bad_op)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: ALU semantics written with plain arithmetic
    function automatic alu_result_t model(input alu_op_t op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [ROB_IDX_SIZE-1:0] dst,
                                          input logic set, input nzcv_t nin);
        alu_result_t r;
        logic [63:0] res;
        logic c, o;
        longint sa, sb, sr;
        int unsigned sh;
        sh = 32'(b[5:0]);
        sa = $signed(a);
        sb = $signed(b);
        c = 1'b0;
        o = 1'b0;
        case (op)
            ALU_PLUS:  res = a + b;
            ALU_MINUS: res = a - b;
            ALU_AND:   res = a & b;
            ALU_OR:    res = a | b;
            ALU_EOR:   res = a ^ b;
            ALU_ORN:   res = a | ~b;
            ALU_MOV:   res = b;
            ALU_LSL:   res = a << sh;
            ALU_LSR:   res = a >> sh;
            ALU_ASR:   res = sa >>> sh;
            default:   res = a;
        endcase
        sr = $signed(res);
        if (op == ALU_PLUS) begin
            c = (res < a);
            o = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
        end else if (op == ALU_MINUS) begin
            c = (a >= b);
            o = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
        end
        r.value         = res;
        r.dst_rob_index = dst;
        r.set_nzcv      = set;
        r.nzcv          = set ? '{n: res[63], z: (res == 64'd0), c: c, v: o} : nin;
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0:       return 64'($urandom_range(0, 3));
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic drive_idle();
        in_rs_start         = 1'b0;
        in_rs_op            = ALU_PLUS;
        in_rs_val_a         = '0;
        in_rs_val_b         = '0;
        in_rs_dst_rob_index = '0;
        in_rs_set_nzcv      = 1'b0;
        in_rs_nzcv          = '0;
        in_rob_accept       = 1'b0;
        in_rob_is_mispred   = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        in_rst = 1'b1;
        step();
        in_rst = 1'b0;
    endtask

    task automatic drive_start(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                               input logic set, input nzcv_t nin, input logic [ROB_IDX_SIZE-1:0] dst);
        in_rs_start         = 1'b1;
        in_rs_op            = op;
        in_rs_val_a         = a;
        in_rs_val_b         = b;
        in_rs_set_nzcv      = set;
        in_rs_nzcv          = nin;
        in_rs_dst_rob_index = dst;
    endtask

    function automatic alu_result_t head();
        return '{value: out_rob_value, dst_rob_index: out_rob_dst_rob_index,
                 set_nzcv: out_rob_set_nzcv, nzcv: out_rob_nzcv};
    endfunction

    // Issue one op into an empty unit, wait (bounded) for done, accept it
    task automatic exec_one(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                            input logic set, input nzcv_t nin, input logic [ROB_IDX_SIZE-1:0] dst,
                            output alu_result_t got, output int lat);
        drive_start(op, a, b, set, nin, dst);
        step();
        in_rs_start = 1'b0;
        lat = 0;
        while (!out_rob_done && lat < 20) begin
            step();
            lat++;
        end
        got = head();
        in_rob_accept = 1'b1;
        step();
        in_rob_accept = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        in_rst = 1'b0;
        drive_start(ALU_PLUS, 64'd1, 64'd2, 1'b1, '0, 4'd1);
        step();
        step();
        in_rst = 1'b1;
        step();
        in_rst = 1'b0;
        drive_idle();
        total++; if (out_rob_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", out_rob_done); end
        total++; if (out_rob_value !== 64'd0) begin bad++; $display("FAIL reset_value got=%h exp=0", out_rob_value); end
        total++; if (out_rob_dst_rob_index !== '0) begin bad++; $display("FAIL reset_dst got=%h exp=0", out_rob_dst_rob_index); end
        total++; if (out_rob_set_nzcv !== 1'b0 || out_rob_nzcv !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b/%b exp=0/0000", out_rob_set_nzcv, out_rob_nzcv); end
        total++; if (out_rs_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", out_rs_ready); end
        total++; if (out_err_overflow !== 1'b0 || out_err_bad_op !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", out_err_overflow, out_err_bad_op); end
        step();
        step();
        total++; if (out_rob_done !== 1'b0) begin bad++; $display("FAIL reset_discard got=%b exp=0", out_rob_done); end
    endtask

    task automatic test_directed();
        alu_op_t     t_op  [5] = '{ALU_PLUS, ALU_MINUS, ALU_MINUS, ALU_PLUS, ALU_ASR};
        logic [63:0] t_a   [5] = '{64'd5, 64'd3, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        logic [63:0] t_b   [5] = '{64'd7, 64'd3, 64'd1, 64'd1, 64'd63};
        logic        t_set [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  t_nin [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0101};
        logic [63:0] t_val [5] = '{64'd12, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [3:0]  t_fl  [5] = '{4'b0000, 4'b0110, 4'b1000, 4'b1001, 4'b0101};
        logic [3:0]  t_dst [5] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd8};
        alu_result_t got;
        int lat;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exec_one(t_op[i], t_a[i], t_b[i], t_set[i], nzcv_t'(t_nin[i]), t_dst[i], got, lat);
            total++; if (lat !== 1) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=1", i, lat); end
            total++; if (got.value !== t_val[i]) begin bad++; $display("FAIL dir%0d_value got=%h exp=%h", i, got.value, t_val[i]); end
            total++; if (got.nzcv !== t_fl[i]) begin bad++; $display("FAIL dir%0d_nzcv got=%b exp=%b", i, got.nzcv, t_fl[i]); end
            total++; if (got.dst_rob_index !== t_dst[i] || got.set_nzcv !== t_set[i]) begin bad++; $display("FAIL dir%0d_dst got=%0d/%b exp=%0d/%b", i, got.dst_rob_index, got.set_nzcv, t_dst[i], t_set[i]); end
        end
    endtask

    task automatic test_back_to_back();
        alu_result_t q[$];
        alu_result_t e;
        logic [63:0] a, b;
        int occ = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            total++;
            if (out_rs_ready !== (occ <= RES_DEPTH - 1)) begin
                bad++; $display("FAIL b2b_ready%0d got=%b exp=%b", k, out_rs_ready, (occ <= RES_DEPTH - 1));
            end
            a = rand64();
            b = rand64();
            drive_start(ALU_PLUS, a, b, 1'b1, '0, 4'(k));
            step();
            if (occ < RES_DEPTH + 1) begin
                occ++;
                q.push_back(model(ALU_PLUS, a, b, 4'(k), 1'b1, '0));
            end
            total++;
            if (out_err_overflow !== (k == 5)) begin
                bad++; $display("FAIL b2b_overflow%0d got=%b exp=%b", k, out_err_overflow, (k == 5));
            end
        end
        drive_idle();
        in_rob_accept = 1'b1;
        for (int c = 0; c < 30 && q.size() != 0; c++) begin
            if (out_rob_done) begin
                e = q.pop_front();
                total++;
                if (head() !== e) begin bad++; $display("FAIL b2b_drain got=%h exp=%h", head(), e); end
            end
            step();
        end
        in_rob_accept = 1'b0;
        total++; if (q.size() != 0) begin bad++; $display("FAIL b2b_drain_timeout got=%0d exp=0 left", q.size()); end
        total++; if (out_rob_done !== 1'b0 || out_rs_ready !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b%b exp=01", out_rob_done, out_rs_ready); end
        total++; if (out_err_overflow !== 1'b1) begin bad++; $display("FAIL b2b_sticky got=%b exp=1", out_err_overflow); end
        do_reset();
        total++; if (out_err_overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf_reset got=%b exp=0", out_err_overflow); end
    endtask

    task automatic test_mispredict();
        alu_result_t got, e;
        int lat;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_start(ALU_MOV, 64'd0, 64'(k + 100), 1'b0, '0, 4'(k));
            step();
        end
        drive_idle();
        step();
        total++; if (out_rob_done !== 1'b1) begin bad++; $display("FAIL mp_buffered got=%b exp=1", out_rob_done); end
        drive_start(ALU_MOV, 64'd0, 64'd999, 1'b0, '0, 4'd9);
        in_rob_is_mispred = 1'b1;
        in_rob_accept     = 1'b1;
        step();
        drive_idle();
        total++; if (out_rob_done !== 1'b0) begin bad++; $display("FAIL mp_done got=%b exp=0", out_rob_done); end
        total++; if (out_rs_ready !== 1'b1) begin bad++; $display("FAIL mp_ready got=%b exp=1", out_rs_ready); end
        for (int c = 0; c < 4; c++) begin
            in_rob_accept = 1'(c & 1);
            step();
            total++; if (out_rob_done !== 1'b0) begin bad++; $display("FAIL mp_stale%0d got=%b exp=0", c, out_rob_done); end
        end
        drive_idle();
        e = model(ALU_PLUS, 64'd40, 64'd2, 4'd7, 1'b1, '0);
        exec_one(ALU_PLUS, 64'd40, 64'd2, 1'b1, '0, 4'd7, got, lat);
        total++; if (got !== e || lat !== 1) begin bad++; $display("FAIL mp_after got=%h lat=%0d exp=%h lat=1", got, lat, e); end
    endtask

    task automatic test_bad_op();
        alu_result_t got, e;
        logic [63:0] a;
        int lat;
        do_reset();
        a = rand64();
        e = model(alu_op_t'(4'd13), a, 64'd5, 4'd2, 1'b1, '0);
        exec_one(alu_op_t'(4'd13), a, 64'd5, 1'b1, '0, 4'd2, got, lat);
        total++; if (got !== e) begin bad++; $display("FAIL badop_value got=%h exp=%h", got, e); end
        total++; if (out_err_bad_op !== 1'b1) begin bad++; $display("FAIL badop_flag got=%b exp=1", out_err_bad_op); end
        total++; if (out_err_overflow !== 1'b0) begin bad++; $display("FAIL badop_ovf got=%b exp=0", out_err_overflow); end
    endtask

    task automatic test_random();
        alu_result_t q[$];
        alu_result_t e;
        alu_op_t op;
        logic [63:0] a, b;
        logic set;
        nzcv_t nin;
        logic [ROB_IDX_SIZE-1:0] dst;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            drive_idle();
            total++;
            if (out_rob_done && q.size() == 0) begin bad++; $display("FAIL rand_phantom cyc=%0d got=1 exp=0", cyc); end
            if ($urandom_range(0, 49) == 0) begin
                in_rob_is_mispred = 1'b1;
                in_rob_accept     = 1'b1;
                in_rs_start       = 1'($urandom_range(0, 1));
                q.delete();
            end else begin
                if (out_rob_done && q.size() != 0 && $urandom_range(0, 2) != 0) begin
                    in_rob_accept = 1'b1;
                    e = q.pop_front();
                    total++;
                    if (head() !== e) begin bad++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", cyc, head(), e); end
                end
                if (out_rs_ready && $urandom_range(0, 3) != 0) begin
                    op  = alu_op_t'(4'($urandom_range(0, 9)));
                    a   = rand64();
                    b   = rand64();
                    set = 1'($urandom_range(0, 1));
                    nin = nzcv_t'(4'($urandom_range(0, 15)));
                    dst = ROB_IDX_SIZE'($urandom_range(0, 15));
                    drive_start(op, a, b, set, nin, dst);
                    q.push_back(model(op, a, b, dst, set, nin));
                end
            end
            step();
        end
        drive_idle();
        in_rob_accept = 1'b1;
        for (int c = 0; c < 40 && q.size() != 0; c++) begin
            if (out_rob_done) begin
                e = q.pop_front();
                total++;
                if (head() !== e) begin bad++; $display("FAIL rand_drain got=%h exp=%h", head(), e); end
            end
            step();
        end
        drive_idle();
        total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain_timeout got=%0d exp=0 left", q.size()); end
        total++; if (out_rob_done !== 1'b0) begin bad++; $display("FAIL rand_done_end got=%b exp=0", out_rob_done); end
        total++; if (out_err_overflow !== 1'b0 || out_err_bad_op !== 1'b0) begin bad++; $display("FAIL rand_err got=%b%b exp=00", out_err_overflow, out_err_bad_op); end
    endtask

    initial begin
        drive_idle();
        in_rst = 1'b1;
        step();
        test_reset();
        test_directed();
        test_back_to_back();
        test_mispredict();
        test_bad_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_functional_unit.md
Name: alu_functional_unit

Overview:
- Integer ALU functional unit directly downstream of the reservation station (RS).
- Accepts one ready instruction per cycle from the RS issue port, computes a 64-bit result and NZCV flags, and buffers results in a small FIFO.
- Results are presented to the ROB with a valid/accept handshake for completion/broadcast.
- Advertises a conservative ready so an RS that samples ready one cycle late never overruns it.

Parameters:
- RES_DEPTH, 4, result FIFO entries (power of two, ≥2).
- RES_IDX_SIZE, 2, log2(RES_DEPTH).

Ports:
- in_clk  input  1  clock; all state updates on posedge.
- in_rst  input  1  synchronous, active-high reset.
- in_rs_start  input  1  issue strobe from RS.
- in_rs_op  input  alu_op_t  operation.
- in_rs_val_a  input  GPR_SIZE  operand A.
- in_rs_val_b  input  GPR_SIZE  operand B.
- in_rs_dst_rob_index  input  ROB_IDX_SIZE  destination ROB entry.
- in_rs_set_nzcv  input  1  instruction writes flags.
- in_rs_nzcv  input  nzcv_t  incoming flags, passed through when not setting.
- in_rob_accept  input  1  ROB consumes the head result this cycle.
- in_rob_is_mispred  input  1  flush all in-flight work.
- out_rs_ready  output  1  RS may issue.
- out_rob_done  output  1  head result valid.
- out_rob_dst_rob_index  output  ROB_IDX_SIZE  head destination.
- out_rob_value  output  GPR_SIZE  head result.
- out_rob_set_nzcv  output  1  head writes flags.
- out_rob_nzcv  output  nzcv_t  head flags.
- out_err_overflow  output  1  sticky: start received with no space.
- out_err_bad_op  output  1  sticky: undecoded op received.

Behaviour:
- Reset: synchronous on in_rst. Clears E1 valid, the FIFO pointers and count, and both error flags. Reset outputs:
  - out_rob_done=0
  - out_rob_value=0
  - out_rob_dst_rob_index=0
  - out_rob_set_nzcv=0
  - out_rob_nzcv=0
  - out_rs_ready=1
  - Reset mid-operation discards all in-flight results.
- Pipeline:
  - Stage E1 is a register capturing the in_rs_* fields when in_rs_start=1.
  - Compute is combinational from E1.
  - The result is written into the FIFO at the next posedge if the FIFO is not full (or is being popped the same cycle). Otherwise E1 holds.
  - Latency: start sampled at posedge t, then out_rob_done=1 after posedge t+1 when the FIFO was empty.
- Occupancy:
  - occ = E1 valid + FIFO count.
  - out_rs_ready is registered: next value = (next_occ ≤ RES_DEPTH−1). This leaves a one-slot skid for the late-sampling RS.
  - Total capacity is RES_DEPTH+1.
  - A start with occ = RES_DEPTH+1 (and no simultaneous drain) is dropped and sets out_err_overflow.
- ROB handshake:
  - out_rob_* always reflect the FIFO head.
  - out_rob_done=1 iff the FIFO is non-empty.
  - Pop on in_rob_accept & out_rob_done; accept while empty is ignored.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo RES_DEPTH.
- Mispredict: in_rob_is_mispred=1 at posedge clears E1 and the FIFO, ignores a same-cycle start and a same-cycle accept, and sets out_rs_ready=1 next cycle.
- Arithmetic (64-bit, two's complement):
  - PLUS: a+b.
  - MINUS: a−b.
  - AND, OR (a|b), EOR (a^b), ORN (a|~b).
  - MOV: b.
  - LSL/LSR/ASR: a shifted by b[5:0].
  - Unknown op: result = val_a, and out_err_bad_op is set.
- Flags:
  - If set_nzcv=0: nzcv = incoming in_rs_nzcv.
  - Otherwise, N=res[63] and Z=(res==0).
  - PLUS: C = carry-out bit 64; V = (a[63]==b[63]) & (res[63]!=a[63]).
  - MINUS: C = (a ≥ b unsigned); V = (a[63]!=b[63]) & (res[63]!=a[63]).
  - All other ops: C=0, V=0.
- Simultaneous events: priority is reset > mispredict > (push, pop, start) applied together.

Decomposition:
- Shared package gains:
  - alu_result_t: value, dst_rob_index, set_nzcv, nzcv.
  - The existing alu_op_t, nzcv_t, GPR_SIZE and ROB_IDX_SIZE are reused unchanged.
- One combinational sub-module, alu_compute (op, a, b, set_nzcv, nzcv_in → result, nzcv_out, bad_op). It is unit-testable in isolation.
- The FIFO is inline.

Test Plan:
- Reset, then start PLUS a=5 b=7 set_nzcv=1 dst=3 → out_rob_done after one posedge with value 12, nzcv 0000, dst 3.
- MINUS a=3 b=3 set_nzcv=1 → value 0, nzcv 0110. MINUS a=0 b=1 → value 0xFFFF_FFFF_FFFF_FFFF, nzcv 1000. PLUS a=0x7FFF_FFFF_FFFF_FFFF b=1 → nzcv 1001.
- Hold in_rob_accept=0 and issue back-to-back starts honouring registered ready:
  - out_rs_ready falls once occ reaches RES_DEPTH.
  - A one-late start is absorbed with no overflow flag.
  - Results later drain in issue order with dst 0,1,2,3,4.
- Fill the unit to occ=RES_DEPTH+1 and issue one more start → it is dropped and out_err_overflow=1 (sticky until reset).
- With 3 results buffered, assert in_rob_is_mispred together with a start → next cycle out_rob_done=0 and out_rs_ready=1, and no stale result ever appears.
- ASR a=0x8000_0000_0000_0000 b=63 set_nzcv=0 nzcv_in=0101 → value all-ones, nzcv 0101 passed through. An undecoded op sets out_err_bad_op.
